// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: shared types and defaults for the UART APB bridge.
package uart_apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } uart_apb_state_e;

    localparam logic [31:0] UART_APB_DEF_BASE = 32'h1600_0000;
    localparam logic [31:0] UART_APB_DEF_MASK = 32'h0000_0fff;

    // Request fields are sized for the widest supported register port; the bridge uses the low bits.
    localparam int UART_APB_MAX_AW = 32;
    localparam int UART_APB_MAX_DW = 64;
    localparam int UART_APB_MAX_BE = UART_APB_MAX_DW / 8;

    typedef struct packed {
        logic [UART_APB_MAX_AW-1:0] addr;
        logic                       we;
        logic [UART_APB_MAX_BE-1:0] be;
        logic [UART_APB_MAX_DW-1:0] wdata;
    } uart_apb_req_t;

endpackage

// File: rtl/uart_apb_tmo.sv
// uart_apb_tmo: register-request timeout counter; expired stays high once the limit is reached.
module uart_apb_tmo #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic pclk_i,
    input  logic prst_ni,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/uart_apb_bridge.sv
// uart_apb_bridge: APB front end for the UART register file with a req/ack register handshake.
// Define UART_APB_TIMEOUT_EN to abort register accesses not acked within TIMEOUT_CYCLES.
module uart_apb_bridge
    import uart_apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    REG_ADDR_WIDTH = 12,
    parameter int                    REG_DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] UART_ADDR_BASE = ADDR_WIDTH'(UART_APB_DEF_BASE),
    parameter logic [ADDR_WIDTH-1:0] UART_ADDR_MASK = ADDR_WIDTH'(UART_APB_DEF_MASK),
    parameter bit                    PRIV_ONLY      = 1'b0,
    parameter int                    TIMEOUT_CYCLES = 64,
    localparam int                   STRB_WIDTH     = DATA_WIDTH / 8,
    localparam int                   REG_BYTES      = REG_DATA_WIDTH / 8
) (
    input  logic                      pclk_i,
    input  logic                      prst_ni,
    input  logic [ADDR_WIDTH-1:0]     paddr_i,
    input  logic [2:0]                pprot_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [DATA_WIDTH-1:0]     pwdata_i,
    input  logic [STRB_WIDTH-1:0]     pstrb_i,
    output logic                      pready_o,
    output logic [DATA_WIDTH-1:0]     prdata_o,
    output logic                      pslverr_o,
    output logic                      reg_req_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_o,
    output logic                      reg_we_o,
    output logic [REG_BYTES-1:0]      reg_be_o,
    output logic [REG_DATA_WIDTH-1:0] reg_wdata_o,
    input  logic                      reg_ack_i,
    input  logic [REG_DATA_WIDTH-1:0] reg_rdata_i,
    input  logic                      reg_err_i
);

    localparam logic [STRB_WIDTH-1:0] BE_MASK = STRB_WIDTH'((1 << REG_BYTES) - 1);

    uart_apb_state_e       state_q, state_d;
    uart_apb_req_t         req_q, req_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_d;
    logic                  dec_err, null_wr, tmo_expired, in_req;
    logic                  unused_bits;

    assign dec_err = ((paddr_i & ~UART_ADDR_MASK) != UART_ADDR_BASE) || (paddr_i[1:0] != 2'b00)
                   || (PRIV_ONLY && !pprot_i[0]) || (pwrite_i && |(pstrb_i & ~BE_MASK));
    assign null_wr = pwrite_i && (pstrb_i[REG_BYTES-1:0] == '0);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        err_d    = err_q;
        prdata_d = prdata_o;
        unique case (state_q)
            IDLE: if (psel_i && penable_i) begin
                req_d.addr  = UART_APB_MAX_AW'({paddr_i[REG_ADDR_WIDTH-1:2], 2'b00});
                req_d.we    = pwrite_i;
                req_d.be    = UART_APB_MAX_BE'(pwrite_i ? pstrb_i[REG_BYTES-1:0] : {REG_BYTES{1'b1}});
                req_d.wdata = UART_APB_MAX_DW'(pwdata_i[REG_DATA_WIDTH-1:0]);
                err_d       = dec_err;
                state_d     = (dec_err || null_wr) ? RESP : REQ;
            end
            REQ: if (reg_ack_i) begin
                err_d    = reg_err_i;
                prdata_d = req_q.we ? prdata_o : DATA_WIDTH'(reg_rdata_i);
                state_d  = RESP;
            end else if (tmo_expired) begin
                err_d   = 1'b1;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            state_q  <= IDLE;
            req_q    <= '0;
            err_q    <= 1'b0;
            prdata_o <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            err_q    <= err_d;
            prdata_o <= prdata_d;
        end
    end

`ifdef UART_APB_TIMEOUT_EN
    uart_apb_tmo #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .pclk_i  (pclk_i),
        .prst_ni (prst_ni),
        .clear   (!in_req),
        .run     (in_req && !reg_ack_i),
        .expired (tmo_expired)
    );
`else
    // Never fires: REQ waits for reg_ack_i indefinitely.
    assign tmo_expired = (TIMEOUT_CYCLES < 0);
`endif

    // Handshake outputs come straight from the state and request flops.
    assign in_req      = state_q == REQ;
    assign pready_o    = state_q == RESP;
    assign pslverr_o   = pready_o && err_q;
    assign reg_req_o   = in_req;
    assign reg_we_o    = in_req && req_q.we;
    assign reg_addr_o  = in_req ? req_q.addr[REG_ADDR_WIDTH-1:0] : '0;
    assign reg_be_o    = in_req ? req_q.be[REG_BYTES-1:0] : '0;
    assign reg_wdata_o = in_req ? req_q.wdata[REG_DATA_WIDTH-1:0] : '0;

    assign unused_bits = ^{pprot_i[2:1], pwdata_i, req_q};

endmodule

// File: doc/uart_apb_bridge.md
# uart_apb_bridge

Parametrised APB-to-register bridge for the UART peripheral family, replacing the fixed single-cycle front end. It decodes and checks APB accesses against the UART address window, then runs a `reg_req_o`/`reg_ack_i` handshake so register banks may take multiple cycles and signal errors. Optional privilege checking, byte enables and a response timeout are included. It sits between the system APB fabric and the UART register file.

## Interface
- `ADDR_WIDTH`, 32, APB address width
- `DATA_WIDTH`, 32, APB data width; `STRB_WIDTH = DATA_WIDTH/8` (localparam)
- `REG_ADDR_WIDTH`, 12, register address width; must be ≤ ADDR_WIDTH
- `REG_DATA_WIDTH`, 16, register data width; multiple of 8, ≤ DATA_WIDTH; `REG_BYTES = REG_DATA_WIDTH/8` (localparam)
- `UART_ADDR_BASE`, 'h1600_0000, window base
- `UART_ADDR_MASK`, 'hfff, window offset mask
- `PRIV_ONLY`, 0, when 1, reject accesses with `pprot_i[0]==0`
- `TIMEOUT_CYCLES`, 64, cycles in REQ before abort (≥2); used only with `UART_APB_TIMEOUT_EN`
- `pclk_i` in 1 clock; the only clock
- `prst_ni` in 1 asynchronous active-low reset
- `paddr_i` in ADDR_WIDTH, APB address
- `pprot_i` in 3, APB protection
- `psel_i`, `penable_i`, `pwrite_i` in 1 each, APB control
- `pwdata_i` in DATA_WIDTH, write data
- `pstrb_i` in STRB_WIDTH, write strobes
- `pready_o` out 1, transfer complete
- `prdata_o` out DATA_WIDTH, read data, zero-extended
- `pslverr_o` out 1, error response
- `reg_req_o` out 1, register request, held until ack or abort
- `reg_addr_o` out REG_ADDR_WIDTH, word-aligned register address
- `reg_we_o` out 1, write request
- `reg_be_o` out REG_BYTES, byte enables
- `reg_wdata_o` out REG_DATA_WIDTH, write data
- `reg_ack_i` in 1, register access done
- `reg_rdata_i` in REG_DATA_WIDTH, read data, valid with ack
- `reg_err_i` in 1, register error, valid with ack

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: sample `psel_i && penable_i`. Latch the following:
  - addr: `paddr_i[REG_ADDR_WIDTH-1:0]` with bits [1:0] forced to 0
  - `pwrite_i`
  - `pwdata_i[REG_DATA_WIDTH-1:0]`
  - `pstrb_i[REG_BYTES-1:0]`
- Decode error: go to RESP with err=1 if any of the following hold:
  - `(paddr_i & ~MASK) != BASE`
  - `paddr_i[1:0] != 0`
  - `PRIV_ONLY && !pprot_i[0]`
  - write with any `pstrb_i` bit ≥ REG_BYTES set
- Write with all latched strobes 0: go to RESP with err=0 and no register request.
- Otherwise go to REQ.
- REQ: `reg_req_o=1`, with address, we, be and wdata stable from the latches.
  - On `reg_ack_i`: go to RESP. Capture `reg_rdata_i` into `prdata_o` on reads only. err = `reg_err_i`.
  - Reads drive `reg_be_o` all ones.
- RESP: `pready_o=1` for exactly one cycle, `pslverr_o` = err, then IDLE.
- Register outputs are driven only in REQ. Outside REQ, `reg_req_o=0` and `reg_we_o=0`.
- `prdata_o` holds its last value between reads and is unchanged by writes and decode errors.
- If `psel_i` drops mid-transfer (protocol violation), the started register access still completes and RESP still pulses.

## Timing
- All APB and register outputs are driven from flops or from the state register only. There is no input-to-output combinational path.
- Reset values: state IDLE; `pready_o`, `pslverr_o`, `reg_req_o`, `reg_we_o` = 0; `prdata_o`, `reg_addr_o`, `reg_be_o`, `reg_wdata_o` = 0. Assertion of `prst_ni` mid-transfer aborts immediately with no RESP.
- First access-phase cycle = T0.
  - Decode error or null write: `pready_o` high in T1.
  - Valid access: `reg_req_o` high from T1. Ack sampled in cycle Tk gives `pready_o` in Tk+1.
  - Minimum valid-access latency: ack in T1, `pready_o` in T2.
- No new access is accepted in RESP. The cycle after RESP, IDLE ignores `penable_i` until `pready_o` is low again, which prevents double-accepting the completing transfer.

## Configuration
- `UART_APB_TIMEOUT_EN` defined:
  - A counter clears on REQ entry and increments each REQ cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES-1` with no ack, `reg_req_o` drops, the FSM goes to RESP with err=1 and `prdata_o` is unchanged.
  - An ack in the same cycle as the timeout wins.
- `UART_APB_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely and `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `uart_apb_pkg` holds:
  - `uart_apb_state_e` (IDLE/REQ/RESP)
  - default base/mask constants
  - a `uart_apb_req_t` struct (addr, we, be, wdata)
- Sub-module `uart_apb_tmo`: the timeout counter, with inputs clear and run and output expired. It is instantiated only under `UART_APB_TIMEOUT_EN`.

## Test plan
- Write 'h1600_0008 data 'hA5A5, strb 'b0011, ack after 3 cycles:
  - `reg_addr_o`='h008, `reg_we_o`=1, `reg_be_o`='b11 held for 3 cycles
  - `pready_o` 1 cycle later with `pslverr_o`=0
- Read 'h1600_0004, ack in T1 with rdata 'h1234: `pready_o` in T2, `prdata_o`='h0000_1234.
- Decode errors each give `pready_o` in T1, `pslverr_o`=1 and no `reg_req_o`:
  - address 'h1700_0000
  - address 'h1600_0002
  - write strb 'b0100
  - `PRIV_ONLY=1` with pprot 'b000
- `reg_err_i`=1 with ack on a read: `pslverr_o`=1 and `prdata_o` updated.
- With `UART_APB_TIMEOUT_EN`, TIMEOUT_CYCLES=8 and no ack:
  - `reg_req_o` high for 8 cycles, then `pready_o` with `pslverr_o`=1
  - rerun with ack on the 8th REQ cycle: `pslverr_o`=0
- `prst_ni` low while in REQ: `reg_req_o` falls asynchronously, no `pready_o`, next transfer completes normally.
